pkt_det_axil_regs: RTL and testbench
====================================

Name: pkt_det_axil_regs

Overview:
AXI4-Lite slave register block: the responder end of the S00_AXI control port that the 11AD packet detector exposes to the PS/VIP master. It holds the detector's configuration registers and publishes its status and a detection counter. It sits between the AXI interconnect and the packet-detector datapath, in the ACLK domain.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
THRESH_RESET, 32'h0000_4000, reset value of the THRESH register.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
det_pulse  in  1  one-cycle packet-detected strobe from the datapath.
det_busy  in  1  detector-active level.
cfg_enable  out  1  CTRL[0].
cfg_thresh  out  32  THRESH register.
cfg_window  out  16  WINDOW[15:0].

Behaviour:
- Register map (word index = addr[4:2]):
  - 0 CTRL RW: bit0 enable; bit1 cnt_clr, self-clearing and reads 0.
  - 1 THRESH RW.
  - 2 WINDOW RW; bits[31:16] reserved, read 0.
  - 3 SCRATCH RW.
  - 4 STATUS RO: bit0 det_busy, bit1 sticky det_seen.
  - 5 DET_CNT RO.
  - 6 and 7: unmapped.
- Reset values: all outputs and handshake signals 0. CTRL=0, THRESH=THRESH_RESET, WINDOW=0, SCRATCH=0, DET_CNT=0, det_seen=0. Reset is asynchronous and may land mid-transaction; any transaction in flight is dropped, no response is issued, and the block restarts in the idle state.
- Write path states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY is high only in W_IDLE and W_HAVE_W; WREADY only in W_IDLE and W_HAVE_AW.
  - Once both are captured, the register update happens on the next edge, with BVALID rising on that same edge.
  - BVALID holds until BREADY, then the FSM returns to W_IDLE. No new AW/W is accepted while in W_RESP.
  - WSTRB is applied per byte.
  - Writes to RO or unmapped words: no state change. RO words return BRESP=OKAY; unmapped words return SLVERR (2'b10).
- Read path states: R_IDLE, R_RESP.
  - ARREADY is high in R_IDLE. On the AR handshake, RDATA is registered and RVALID=1 on the next edge.
  - RDATA and RRESP hold stable until RREADY. Unmapped words return RDATA=0, RRESP=SLVERR.
  - Read and write paths run concurrently.
- DET_CNT: 32-bit counter incremented on det_pulse while cfg_enable=1. It saturates at 32'hFFFF_FFFF and does not wrap.
- cnt_clr write: clears DET_CNT and det_seen. If det_pulse occurs in the same cycle, the clear wins and the result is 0.
- det_seen: set by any det_pulse while enabled; cleared only by cnt_clr.
- Read of DET_CNT in the same cycle as an increment returns the pre-increment value.

Optional Feature:
PKT_DET_AXIL_IRQ_EN:
- Defined: adds output port irq (1 bit) and register 6 IRQ_MASK (RW, bit0, reset 0), which becomes mapped.
  - irq = det_seen & IRQ_MASK[0], registered (one cycle after det_seen sets).
- Undefined: no irq port; word 6 remains unmapped and returns SLVERR.

Test Plan:
1. Write 1,2,3,4 to addr 0x00/04/08/0C, then read back -> 0x00000001 (cnt_clr not retained), 0x2, 0x3, 0x4; all responses OKAY.
2. W presented 3 cycles before AW to addr 0x0C with data 0xA5A5A5A5, WSTRB=4'b0101 (SCRATCH previously 0) -> read returns 0x00A500A5; exactly one BVALID.
3. Enable=1; 5 det_pulse -> DET_CNT=5, STATUS=0x2. Write CTRL=0x3 -> DET_CNT=0, STATUS bit1=0.
4. Read 0x1C and write 0x18 (IRQ_EN undefined) -> RRESP=2'b10, RDATA=0; BRESP=2'b10; no register changes.
5. Hold BREADY and RREADY low 10 cycles -> BVALID, RVALID, RDATA stable; no further AWREADY/ARREADY.
6. Assert ARESETN=0 between the AW and W handshakes -> after release, no BVALID and THRESH=0x00004000.

Source files
------------

// File: rtl/pkt_det_axil_regs.sv
// AXI4-Lite register block for the 11AD packet detector: config registers, status and detection counter.
// Optional IRQ output and IRQ_MASK register (word 6) are built when PKT_DET_AXIL_IRQ_EN is defined.
module pkt_det_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] THRESH_RESET       = 32'h0000_4000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              det_pulse,
    input  logic                              det_busy,
    output logic                              cfg_enable,
    output logic [31:0]                       cfg_thresh,
    output logic [15:0]                       cfg_window,
`ifdef PKT_DET_AXIL_IRQ_EN
    output logic                              irq,
`endif
    output logic [1:0]                        dbg_wr_state_o,
    output logic                              dbg_rd_state_o
);

    // Handshake rule: a beat transfers on a rising ACLK edge where VALID and READY are both high;
    // VALID never waits on READY, and BVALID/RVALID with their payload hold until BREADY/RREADY.
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_RESP} rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_THRESH   = 3'd1;
    localparam logic [2:0] IDX_WINDOW   = 3'd2;
    localparam logic [2:0] IDX_SCRATCH  = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;
    localparam logic [2:0] IDX_DET_CNT  = 3'd5;
    localparam logic [2:0] IDX_IRQ_MASK = 3'd6;

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        ready_en_q;
    logic [2:0]  awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        enable_q, enable_d;
    logic [31:0] thresh_q, thresh_d;
    logic [15:0] window_q, window_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] det_cnt_q, det_cnt_d;
    logic        det_seen_q, det_seen_d;
`ifdef PKT_DET_AXIL_IRQ_EN
    logic        irq_mask_q, irq_mask_d;
    logic        irq_q;
`endif

    logic        wr_fire;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        cnt_clr;
    logic [31:0] rd_word;
    logic        rd_ok;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [1:0] wr_resp(input logic [2:0] idx);
        logic [1:0] r;
        case (idx)
            IDX_CTRL, IDX_THRESH, IDX_WINDOW, IDX_SCRATCH, IDX_STATUS, IDX_DET_CNT: r = RESP_OKAY;
`ifdef PKT_DET_AXIL_IRQ_EN
            IDX_IRQ_MASK: r = RESP_OKAY;
`endif
            default: r = RESP_SLVERR;
        endcase
        return r;
    endfunction

    // Write FSM: the register write fires on the edge that completes the second of AW/W.
    always_comb begin
        wr_state_d    = wr_state_q;
        awidx_d       = awidx_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        wr_fire       = 1'b0;
        wr_idx        = awidx_q;
        wr_data       = wdata_q;
        wr_strb       = wstrb_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                S_AXI_AWREADY = ready_en_q;
                S_AXI_WREADY  = ready_en_q;
                if (ready_en_q && S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_fire    = 1'b1;
                    wr_idx     = S_AXI_AWADDR[4:2];
                    wr_data    = S_AXI_WDATA;
                    wr_strb    = S_AXI_WSTRB;
                    wr_state_d = W_RESP;
                end else if (ready_en_q && S_AXI_AWVALID) begin
                    awidx_d    = S_AXI_AWADDR[4:2];
                    wr_state_d = W_HAVE_AW;
                end else if (ready_en_q && S_AXI_WVALID) begin
                    wdata_d    = S_AXI_WDATA;
                    wstrb_d    = S_AXI_WSTRB;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    wr_fire    = 1'b1;
                    wr_data    = S_AXI_WDATA;
                    wr_strb    = S_AXI_WSTRB;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) begin
                    wr_fire    = 1'b1;
                    wr_idx     = S_AXI_AWADDR[4:2];
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        bresp_d    = wr_fire ? wr_resp(wr_idx) : bresp_q;
        enable_d   = enable_q;
        thresh_d   = thresh_q;
        window_d   = window_q;
        scratch_d  = scratch_q;
        det_cnt_d  = det_cnt_q;
        det_seen_d = det_seen_q;
        cnt_clr    = 1'b0;
`ifdef PKT_DET_AXIL_IRQ_EN
        irq_mask_d = irq_mask_q;
`endif
        if (wr_fire) begin
            case (wr_idx)
                IDX_CTRL: begin
                    if (wr_strb[0]) begin
                        enable_d = wr_data[0];
                        cnt_clr  = wr_data[1];
                    end
                end
                IDX_THRESH:  thresh_d  = apply_strb(thresh_q, wr_data, wr_strb);
                IDX_WINDOW: begin
                    if (wr_strb[0]) window_d[7:0]  = wr_data[7:0];
                    if (wr_strb[1]) window_d[15:8] = wr_data[15:8];
                end
                IDX_SCRATCH: scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
`ifdef PKT_DET_AXIL_IRQ_EN
                IDX_IRQ_MASK: if (wr_strb[0]) irq_mask_d = wr_data[0];
`endif
                default: ;
            endcase
        end
        // A clear request beats a coincident detection.
        if (cnt_clr) begin
            det_cnt_d  = '0;
            det_seen_d = 1'b0;
        end else if (det_pulse && enable_q) begin
            det_seen_d = 1'b1;
            if (det_cnt_q != 32'hFFFF_FFFF) det_cnt_d = det_cnt_q + 32'd1;
        end
    end

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        case (S_AXI_ARADDR[4:2])
            IDX_CTRL:     rd_word = {31'd0, enable_q};
            IDX_THRESH:   rd_word = thresh_q;
            IDX_WINDOW:   rd_word = {16'd0, window_q};
            IDX_SCRATCH:  rd_word = scratch_q;
            IDX_STATUS:   rd_word = {30'd0, det_seen_q, det_busy};
            IDX_DET_CNT:  rd_word = det_cnt_q;
`ifdef PKT_DET_AXIL_IRQ_EN
            IDX_IRQ_MASK: rd_word = {31'd0, irq_mask_q};
`endif
            default:      rd_ok   = 1'b0;
        endcase
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        S_AXI_ARREADY = ready_en_q && (rd_state_q == R_IDLE);
        if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            rdata_d    = rd_word;
            rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
            rd_state_d = R_RESP;
        end else if (rd_state_q == R_RESP && S_AXI_RREADY) begin
            rd_state_d = R_IDLE;
        end
    end

    // ready_en_q keeps every READY low during reset and for the first cycle after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            ready_en_q <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            enable_q   <= 1'b0;
            thresh_q   <= THRESH_RESET;
            window_q   <= '0;
            scratch_q  <= '0;
            det_cnt_q  <= '0;
            det_seen_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= 1'b1;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            enable_q   <= enable_d;
            thresh_q   <= thresh_d;
            window_q   <= window_d;
            scratch_q  <= scratch_d;
            det_cnt_q  <= det_cnt_d;
            det_seen_q <= det_seen_d;
        end
    end

`ifdef PKT_DET_AXIL_IRQ_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= det_seen_q & irq_mask_q;
        end
    end
    assign irq = irq_q;
`endif

    assign S_AXI_BVALID   = (wr_state_q == W_RESP);
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_RVALID   = (rd_state_q == R_RESP);
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = rresp_q;
    assign cfg_enable     = enable_q;
    assign cfg_thresh     = thresh_q;
    assign cfg_window     = window_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pkt_det_axil_regs.sv
// Directed bench for pkt_det_axil_regs: AXI-Lite driver tasks, response scoreboard queues, summary line.
module tb_pkt_det_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef PKT_DET_AXIL_IRQ_EN
    localparam logic [1:0] W6_RESP = OKAY;
`else
    localparam logic [1:0] W6_RESP = SLVERR;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        det_pulse = 0, det_busy = 0;
    logic        awready, wready, bvalid, arready, rvalid, cfg_enable;
    logic [1:0]  bresp, rresp, dbg_wr_state;
    logic        dbg_rd_state;
    logic [31:0] rdata, cfg_thresh;
    logic [15:0] cfg_window;
`ifdef PKT_DET_AXIL_IRQ_EN
    logic        irq;
`endif

    pkt_det_axil_regs dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .det_pulse(det_pulse), .det_busy(det_busy),
        .cfg_enable(cfg_enable), .cfg_thresh(cfg_thresh), .cfg_window(cfg_window),
`ifdef PKT_DET_AXIL_IRQ_EN
        .irq(irq),
`endif
        .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    logic [1:0]  rresp_exp_q[$];
    logic [1:0]  bresp_exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; completes the B handshake.
    task automatic wait_b(input string tag);
        int cyc;
        logic [1:0] er;
        cyc = 0;
        bready = 1;
        while (!bvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        er = bresp_exp_q.pop_front();
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        if (bvalid) check({tag, "_bresp"}, 32'(bresp), 32'(er));
        @(posedge clk);
        #1 bready = 0;
    endtask

    task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er, input bit pulse_hs);
        int cyc;
        bit aw_go, w_go;
        bresp_exp_q.push_back(er);
        @(negedge clk);
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 50) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            if (pulse_hs && aw_go && w_go) det_pulse = 1;
            @(posedge clk);
            #1;
            if (aw_go) awvalid = 0;
            if (w_go) wvalid = 0;
            det_pulse = 0;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_addr_data_accepted"}, 32'(awvalid || wvalid), 32'd0);
        awvalid = 0; wvalid = 0;
        wait_b(tag);
    endtask

    task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input bit pulse_hs);
        int cyc;
        logic [31:0] e_d;
        logic [1:0]  e_r;
        exp_q.push_back(ed);
        rresp_exp_q.push_back(er);
        @(negedge clk);
        araddr = a; arvalid = 1;
        cyc = 0;
        while (!arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ar_accepted"}, 32'(arready), 32'd1);
        if (pulse_hs) det_pulse = 1;
        @(posedge clk);
        #1 arvalid = 0; det_pulse = 0;
        rready = 1;
        cyc = 0;
        @(negedge clk);
        while (!rvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        e_d = exp_q.pop_front();
        e_r = rresp_exp_q.pop_front();
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        if (rvalid) begin
            check({tag, "_rdata"}, rdata, e_d);
            check({tag, "_rresp"}, 32'(rresp), 32'(e_r));
        end
        @(posedge clk);
        #1 rready = 0;
    endtask

    task automatic pulse_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); det_pulse = 1;
            @(negedge clk); det_pulse = 0;
        end
    endtask

    initial begin : main
        int  cyc, b_count;
        bit  stable, no_ready;
        logic [31:0] rd0, e_d;
        logic [1:0]  e_r, e_b, b_obs;

        // reset state
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_cfg_enable", 32'(cfg_enable), 32'd0);
        check("rst_cfg_thresh", cfg_thresh, 32'h0000_4000);
        check("rst_cfg_window", 32'(cfg_window), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // basic write/read-back; cnt_clr bit does not stick
        axi_write("wr_ctrl", 5'h00, 32'h1, 4'hF, OKAY, 0);
        axi_write("wr_thresh", 5'h04, 32'h2, 4'hF, OKAY, 0);
        axi_write("wr_window", 5'h08, 32'h3, 4'hF, OKAY, 0);
        axi_write("wr_scratch", 5'h0C, 32'h4, 4'hF, OKAY, 0);
        axi_read("rd_ctrl", 5'h00, 32'h1, OKAY, 0);
        axi_read("rd_thresh", 5'h04, 32'h2, OKAY, 0);
        axi_read("rd_window", 5'h08, 32'h3, OKAY, 0);
        axi_read("rd_scratch", 5'h0C, 32'h4, OKAY, 0);
        check("cfg_enable_on", 32'(cfg_enable), 32'd1);
        check("cfg_thresh_2", cfg_thresh, 32'h2);
        axi_write("wr_window_hi", 5'h08, 32'h1234_5678, 4'hF, OKAY, 0);
        axi_read("rd_window_rsvd", 5'h08, 32'h0000_5678, OKAY, 0);
        check("cfg_window_5678", 32'(cfg_window), 32'h5678);

        // W leads AW by 3 cycles, partial strobes
        axi_write("wr_scratch_0", 5'h0C, 32'h0, 4'hF, OKAY, 0);
        @(negedge clk);
        wdata = 32'hA5A5_A5A5; wstrb = 4'b0101; wvalid = 1;
        cyc = 0;
        while (!wready && cyc < 50) begin @(negedge clk); cyc++; end
        check("wfirst_w_accepted", 32'(wready), 32'd1);
        @(posedge clk);
        #1 wvalid = 0;
        repeat (3) @(negedge clk);
        check("wfirst_no_early_b", 32'(bvalid), 32'd0);
        bresp_exp_q.push_back(OKAY);
        awaddr = 5'h0C; awvalid = 1;
        cyc = 0;
        while (!awready && cyc < 50) begin @(negedge clk); cyc++; end
        check("wfirst_aw_accepted", 32'(awready), 32'd1);
        @(posedge clk);
        #1 awvalid = 0; bready = 1;
        b_count = 0; b_obs = 2'bxx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bvalid) begin b_count++; b_obs = bresp; end
        end
        bready = 0;
        e_b = bresp_exp_q.pop_front();
        check("wfirst_one_bvalid", 32'(b_count), 32'd1);
        check("wfirst_bresp", 32'(b_obs), 32'(e_b));
        axi_read("rd_scratch_strb", 5'h0C, 32'h00A5_00A5, OKAY, 0);

        // detection counter, sticky flag, clear
        pulse_n(5);
        axi_read("rd_cnt5", 5'h14, 32'd5, OKAY, 0);
        axi_read("rd_status_seen", 5'h10, 32'h2, OKAY, 0);
        det_busy = 1;
        axi_read("rd_status_busy", 5'h10, 32'h3, OKAY, 0);
        det_busy = 0;
        axi_write("wr_ctrl_clr", 5'h00, 32'h3, 4'hF, OKAY, 0);
        axi_read("rd_cnt_cleared", 5'h14, 32'd0, OKAY, 0);
        axi_read("rd_status_cleared", 5'h10, 32'h0, OKAY, 0);
        axi_read("rd_ctrl_clr_self", 5'h00, 32'h1, OKAY, 0);
        pulse_n(2);
        axi_write("wr_clr_vs_pulse", 5'h00, 32'h3, 4'hF, OKAY, 1);
        axi_read("rd_clr_wins", 5'h14, 32'd0, OKAY, 0);
        axi_read("rd_status_clr_wins", 5'h10, 32'h0, OKAY, 0);
        axi_read("rd_cnt_pre_inc", 5'h14, 32'd0, OKAY, 1);
        axi_read("rd_cnt_post_inc", 5'h14, 32'd1, OKAY, 0);
        axi_write("wr_ctrl_off", 5'h00, 32'h0, 4'hF, OKAY, 0);
        check("cfg_enable_off", 32'(cfg_enable), 32'd0);
        pulse_n(3);
        axi_read("rd_cnt_disabled", 5'h14, 32'd1, OKAY, 0);

        // unmapped / read-only words
        axi_read("rd_word7", 5'h1C, 32'h0, SLVERR, 0);
        axi_read("rd_word6", 5'h18, 32'h0, W6_RESP, 0);
        axi_write("wr_word6", 5'h18, 32'hFFFF_FFFE, 4'hF, W6_RESP, 0);
        axi_write("wr_word7", 5'h1C, 32'hFFFF_FFFF, 4'hF, SLVERR, 0);
        axi_write("wr_status_ro", 5'h10, 32'hFFFF_FFFF, 4'hF, OKAY, 0);
        axi_write("wr_cnt_ro", 5'h14, 32'hFFFF_FFFF, 4'hF, OKAY, 0);
        axi_read("rd_cnt_after_ro", 5'h14, 32'd1, OKAY, 0);
        axi_read("rd_status_after_ro", 5'h10, 32'h2, OKAY, 0);
        axi_read("rd_thresh_kept", 5'h04, 32'h2, OKAY, 0);
        axi_read("rd_scratch_kept", 5'h0C, 32'h00A5_00A5, OKAY, 0);
        axi_read("rd_ctrl_kept", 5'h00, 32'h0, OKAY, 0);

        // back-pressure on B and R together
        bresp_exp_q.push_back(OKAY);
        exp_q.push_back(32'h2);
        rresp_exp_q.push_back(OKAY);
        @(negedge clk);
        awaddr = 5'h0C; wdata = 32'h1122_3344; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 5'h04; arvalid = 1;
        cyc = 0;
        while (!(awready && wready && arready) && cyc < 50) begin @(negedge clk); cyc++; end
        check("stall_all_accepted", 32'(awready && wready && arready), 32'd1);
        @(posedge clk);
        #1 awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        rd0 = rdata;
        stable = 1; no_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bvalid || !rvalid || rdata !== rd0) stable = 0;
            if (awready || wready || arready) no_ready = 0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_no_ready", 32'(no_ready), 32'd1);
        e_d = exp_q.pop_front();
        e_r = rresp_exp_q.pop_front();
        e_b = bresp_exp_q.pop_front();
        check("stall_rdata", rdata, e_d);
        check("stall_rresp", 32'(rresp), 32'(e_r));
        check("stall_bresp", 32'(bresp), 32'(e_b));
        bready = 1; rready = 1;
        @(posedge clk);
        #1 bready = 0; rready = 0;
        @(negedge clk);
        check("stall_released", 32'({bvalid, rvalid}), 32'd0);
        axi_read("rd_scratch_stall", 5'h0C, 32'h1122_3344, OKAY, 0);

        // reset between AW and W
        @(negedge clk);
        awaddr = 5'h04; awvalid = 1;
        cyc = 0;
        while (!awready && cyc < 50) begin @(negedge clk); cyc++; end
        check("mid_rst_aw_accepted", 32'(awready), 32'd1);
        @(posedge clk);
        #1 awvalid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_thresh", cfg_thresh, 32'h0000_4000);
        check("mid_rst_wready", 32'(wready), 32'd0);
        @(negedge clk);
        rst_n = 1;
        bready = 1;
        b_count = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bvalid) b_count++;
        end
        bready = 0;
        check("mid_rst_no_b", 32'(b_count), 32'd0);
        axi_read("rd_thresh_rst", 5'h04, 32'h0000_4000, OKAY, 0);
        axi_read("rd_scratch_rst", 5'h0C, 32'h0, OKAY, 0);
        axi_read("rd_cnt_rst", 5'h14, 32'h0, OKAY, 0);
        axi_read("rd_status_rst", 5'h10, 32'h0, OKAY, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
